// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC burst,
// with a per-access ack watchdog that returns ERR to the owner on slave timeout.
module wb_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0][31:0] i_m_adr,
  input  logic [1:0][31:0] i_m_dat,
  input  logic [1:0]       i_m_we,
  input  logic [1:0][3:0]  i_m_sel,
  input  logic [1:0]       i_m_stb,
  input  logic [1:0]       i_m_cyc,
  output logic [31:0]      o_m_dat,
  output logic [1:0]       o_m_ack,
  output logic [1:0]       o_m_err,
  output logic [31:0]      o_s_adr,
  output logic [31:0]      o_s_dat,
  output logic             o_s_we,
  output logic [3:0]       o_s_sel,
  output logic             o_s_stb,
  output logic             o_s_cyc,
  input  logic [31:0]      i_s_dat,
  input  logic             i_s_ack,
  output logic [1:0]       o_grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state;
  logic [1:0]           r_grant;
  logic                 r_last;
  logic [CNT_WIDTH-1:0] r_wdCnt;
  logic                 r_errPulse;

  logic                 w_ownerStb;
  logic                 w_release;
  logic [1:0]           w_req;
  logic [1:0]           w_pick;

  // AND-OR mux on the one-hot grant yields an all-zero bus when idle
  assign o_s_adr = ({32{r_grant[0]}} & i_m_adr[0]) | ({32{r_grant[1]}} & i_m_adr[1]);
  assign o_s_dat = ({32{r_grant[0]}} & i_m_dat[0]) | ({32{r_grant[1]}} & i_m_dat[1]);
  assign o_s_sel = ({4{r_grant[0]}} & i_m_sel[0]) | ({4{r_grant[1]}} & i_m_sel[1]);
  assign o_s_we  = |(r_grant & i_m_we);
  assign o_s_cyc = |(r_grant & i_m_cyc);

  assign w_ownerStb = |(r_grant & i_m_stb);
  assign o_s_stb    = w_ownerStb & ~r_errPulse;

  assign o_m_dat = i_s_dat;
  assign o_m_ack = r_grant & {2{i_s_ack & o_s_stb}};
  assign o_m_err = r_grant & {2{r_errPulse}};
  assign o_grant = r_grant;

  assign w_release = (r_state == BUSY) && !(|(r_grant & i_m_cyc));
  assign w_req     = ((r_state == IDLE) || w_release) ? i_m_cyc : 2'b00;

  // On a tie the master that did not win last time gets the bus
  always_comb begin
    w_pick = 2'b00;
    case (w_req)
      2'b01:   w_pick = 2'b01;
      2'b10:   w_pick = 2'b10;
      2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
      default: w_pick = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_wdCnt    <= '0;
      r_errPulse <= 1'b0;
    end else begin
      r_errPulse <= 1'b0;
      if ((r_state == IDLE) || w_release) begin
        r_grant <= w_pick;
        r_wdCnt <= '0;
        if (w_pick != 2'b00) begin
          r_state <= BUSY;
          r_last  <= w_pick[1];
        end else begin
          r_state <= IDLE;
        end
      end else if (o_s_stb && !i_s_ack) begin
        // Ack arriving in the expiry cycle takes the other branch and wins
        if (r_wdCnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          r_wdCnt    <= '0;
          r_errPulse <= 1'b1;
        end else begin
          r_wdCnt <= r_wdCnt + 1'b1;
        end
      end else begin
        r_wdCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Scoreboard bench for wb_master_arbiter: stimulus pushes expected ack/err events,
// a negedge monitor pops and compares them whenever the DUT responds.
module tb_wb_master_arbiter;

  localparam int TO = 8;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [1:0][31:0] i_m_adr;
  logic [1:0][31:0] i_m_dat;
  logic [1:0]       i_m_we;
  logic [1:0][3:0]  i_m_sel;
  logic [1:0]       i_m_stb;
  logic [1:0]       i_m_cyc;
  logic [31:0]      o_m_dat;
  logic [1:0]       o_m_ack;
  logic [1:0]       o_m_err;
  logic [31:0]      o_s_adr;
  logic [31:0]      o_s_dat;
  logic             o_s_we;
  logic [3:0]       o_s_sel;
  logic             o_s_stb;
  logic             o_s_cyc;
  logic [31:0]      i_s_dat;
  logic             i_s_ack;
  logic [1:0]       o_grant;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   lastWin;

  wb_master_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .i_m_we(i_m_we), .i_m_sel(i_m_sel),
    .i_m_stb(i_m_stb), .i_m_cyc(i_m_cyc),
    .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
    .o_s_stb(o_s_stb), .o_s_cyc(o_s_cyc),
    .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pushExp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat);
    exp_t e;
    e.ack = ack;
    e.err = err;
    e.dat = dat;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] adr, input logic we);
    i_m_adr[m] = adr;
    i_m_dat[m] = $urandom;
    i_m_we[m]  = we;
    i_m_sel[m] = 4'hF;
    i_m_stb[m] = 1'b1;
    i_m_cyc[m] = 1'b1;
  endtask

  task automatic dropMaster(input int m);
    i_m_cyc[m] = 1'b0;
    i_m_stb[m] = 1'b0;
    i_m_we[m]  = 1'b0;
  endtask

  task automatic waitGrant(input int m);
    int n = 0;
    logic [1:0] want;
    want = 2'b01 << m;
    while (o_grant == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("grant", {30'd0, o_grant}, {30'd0, want});
  endtask

  // Grants master m, acks 'beats' beats each after 'delay' wait cycles, then releases
  task automatic serve(input int m, input int beats, input int delay);
    logic [31:0] d;
    waitGrant(m);
    checkOutput("s_adr", o_s_adr, i_m_adr[m]);
    checkOutput("s_we", {31'd0, o_s_we}, {31'd0, i_m_we[m]});
    for (int b = 0; b < beats; b++) begin
      repeat (delay) tick();
      d = $urandom;
      i_s_dat = d;
      i_s_ack = 1'b1;
      pushExp(2'b01 << m, 2'b00, d);
      tick();
      i_s_ack = 1'b0;
    end
    dropMaster(m);
    tick();
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    i_m_cyc = '0;
    i_m_stb = '0;
    i_m_we  = '0;
    i_s_ack = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_grant == 2'b11) begin
        checks++;
        errors++;
        $display("[TB] FAIL dualGrant: got %b expected one-hot or 00", o_grant);
      end
      if ((o_m_ack | o_m_err) != 2'b00) begin
        checkOutput("ownerOnly", {30'd0, (o_m_ack | o_m_err) & ~o_grant}, 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected: got ack %b err %b expected nothing", o_m_ack, o_m_err);
        end else begin
          monE = expQ.pop_front();
          checkOutput("ack", {30'd0, o_m_ack}, {30'd0, monE.ack});
          checkOutput("err", {30'd0, o_m_err}, {30'd0, monE.err});
          if (monE.ack != 2'b00) checkOutput("rdata", o_m_dat, monE.dat);
        end
      end
    end
  end

  initial begin
    int reqMask;
    int first;
    int other;
    i_m_adr = '0;
    i_m_dat = '0;
    i_m_sel = '0;
    i_s_dat = '0;
    doReset();
    i_reset = 1'b1;
    tick();
    checkOutput("rstGrant", {30'd0, o_grant}, 32'd0);
    checkOutput("rstAck", {30'd0, o_m_ack}, 32'd0);
    checkOutput("rstErr", {30'd0, o_m_err}, 32'd0);
    checkOutput("rstStbCyc", {30'd0, o_s_stb, o_s_cyc}, 32'd0);
    checkOutput("rstWeSel", {27'd0, o_s_we, o_s_sel}, 32'd0);
    i_reset = 1'b0;

    $display("[TB] single read from master 0");
    applyStimulus(0, 32'h0000_0010, 1'b0);
    serve(0, 1, 1);

    $display("[TB] alternation over four bursts");
    doReset();
    applyStimulus(0, 32'h0000_0100, 1'b0);
    applyStimulus(1, 32'h0000_0200, 1'b1);
    serve(0, 1, 0);
    checkOutput("handoff01", {30'd0, o_grant}, 32'd2);
    serve(1, 1, 0);
    applyStimulus(0, 32'h0000_0104, 1'b0);
    applyStimulus(1, 32'h0000_0204, 1'b0);
    serve(0, 2, 1);
    serve(1, 1, 1);

    $display("[TB] master 0 waits behind a 3-beat master 1 burst");
    applyStimulus(1, 32'h0000_0300, 1'b1);
    waitGrant(1);
    applyStimulus(0, 32'h0000_0400, 1'b0);
    serve(1, 3, 1);
    checkOutput("handoff10", {30'd0, o_grant}, 32'd1);
    serve(0, 1, 0);

    $display("[TB] watchdog expiry");
    applyStimulus(0, 32'h3000_0000, 1'b0);
    waitGrant(0);
    repeat (TO - 1) tick();
    checkOutput("noEarlyErr", {30'd0, o_m_err}, 32'd0);
    pushExp(2'b00, 2'b01, 32'd0);
    tick();
    checkOutput("errAtExpiry", {30'd0, o_m_err}, 32'd1);
    checkOutput("stbForcedLow", {31'd0, o_s_stb}, 32'd0);
    tick();
    checkOutput("errOnePulse", {30'd0, o_m_err}, 32'd0);
    checkOutput("grantHeld", {30'd0, o_grant}, 32'd1);
    dropMaster(0);
    tick();

    $display("[TB] ack in expiry cycle");
    applyStimulus(0, 32'h3000_0000, 1'b0);
    waitGrant(0);
    repeat (TO - 1) tick();
    i_s_dat = 32'hCAFE_0008;
    i_s_ack = 1'b1;
    pushExp(2'b01, 2'b00, 32'hCAFE_0008);
    tick();
    i_s_ack = 1'b0;
    checkOutput("ackWinsNoErr", {30'd0, o_m_err}, 32'd0);
    dropMaster(0);
    tick();

    $display("[TB] reset during master 1 write burst");
    applyStimulus(1, 32'h0000_0500, 1'b1);
    waitGrant(1);
    i_s_dat = 32'h0000_5555;
    i_s_ack = 1'b1;
    pushExp(2'b10, 2'b00, 32'h0000_5555);
    tick();
    i_s_ack = 1'b0;
    i_reset = 1'b1;
    tick();
    checkOutput("midRstGrant", {30'd0, o_grant}, 32'd0);
    checkOutput("midRstCyc", {31'd0, o_s_cyc}, 32'd0);
    checkOutput("midRstStb", {31'd0, o_s_stb}, 32'd0);
    i_reset = 1'b0;
    applyStimulus(0, 32'h0000_0600, 1'b0);
    serve(0, 1, 0);
    serve(1, 2, 0);

    $display("[TB] random two-master traffic");
    doReset();
    lastWin = 1;
    for (int i = 0; i < 12; i++) begin
      reqMask = $urandom_range(1, 3);
      if (reqMask[0]) applyStimulus(0, $urandom, 1'($urandom_range(0, 1)));
      if (reqMask[1]) applyStimulus(1, $urandom, 1'($urandom_range(0, 1)));
      if (reqMask == 3) begin
        first = 1 - lastWin;
        other = lastWin;
        serve(first, $urandom_range(1, 3), $urandom_range(0, 2));
        serve(other, $urandom_range(1, 3), $urandom_range(0, 2));
        lastWin = other;
      end else begin
        first = (reqMask == 2) ? 1 : 0;
        serve(first, $urandom_range(1, 3), $urandom_range(0, 2));
        lastWin = first;
      end
    end

    tick();
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
